motor_pwm_slave: RTL and testbench

//  Avalon-MM slave that owns NUM_MOTORS H-bridge channels end to end.
//  - Per-channel enable/direction and duty registers; internal PWM generation.
//  - Readback of every register.
//  - Glitch-free duty updates at PWM period boundaries.
//  - Communication watchdog that stops all motors when software goes silent.
//  - Output drives GPIO pins in the SOPC configuration.

---
 rtl/motor_pwm_slave.sv | 147 ++++++++++++++
 tb/tb_motor_pwm_slave.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_slave.sv
// Avalon-MM H-bridge PWM controller: per-channel CTRL/DUTY registers with period-aligned
// duty updates, full readback, and a write-activity watchdog that drops every enable.
module motor_pwm_slave #(
    parameter int unsigned NUM_MOTORS      = 6,
    parameter int unsigned DUTY_WIDTH      = 8,
    parameter int unsigned WATCHDOG_CYCLES = 50000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    chipselect,
    input  logic                    write,
    input  logic                    read,
    input  logic [4:0]              addr,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [2*NUM_MOTORS-1:0] GPIO_out,
    output logic                    wd_tripped
);

    localparam logic [DUTY_WIDTH-1:0] CNT_LAST = {{(DUTY_WIDTH-1){1'b1}}, 1'b0};

    logic                    w_wr;
    logic                    w_rd;
    logic                    w_wrap;
    logic                    w_expire;
    logic                    w_tripped;
    logic                    w_trip_clr;
    logic                    w_unused;
    logic [3:0]              w_ch;
    logic [31:0]             w_rdata;
    logic [2*NUM_MOTORS-1:0] w_gpio;

    logic [DUTY_WIDTH-1:0]   r_cnt;
    logic [NUM_MOTORS-1:0]   r_en;
    logic [NUM_MOTORS-1:0]   r_dir;
    logic [DUTY_WIDTH-1:0]   r_shadow [NUM_MOTORS];
    logic [DUTY_WIDTH-1:0]   r_active [NUM_MOTORS];
    logic [31:0]             r_readdata;
    logic [2*NUM_MOTORS-1:0] r_gpio;

    assign w_wr       = chipselect & write;
    assign w_rd       = chipselect & read;
    assign w_ch       = addr[3:0];
    assign w_wrap     = (r_cnt == CNT_LAST);
    assign w_trip_clr = w_wr && (addr == 5'h0F) && writedata[0];
    assign w_unused   = ^writedata;

    // Counter saturates at the last idle cycle, so expiry stays asserted until a write.
    if (WATCHDOG_CYCLES > 0) begin : g_wd
        localparam int unsigned     WD_W    = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
        localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

        logic [WD_W-1:0] r_wd_cnt;
        logic            r_trip;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_wd_cnt <= '0;
                r_trip   <= 1'b0;
            end else begin
                if (w_wr)
                    r_wd_cnt <= '0;
                else if (r_wd_cnt != WD_LAST)
                    r_wd_cnt <= r_wd_cnt + 1'b1;

                if (w_trip_clr)
                    r_trip <= 1'b0;
                else if (w_expire)
                    r_trip <= 1'b1;
            end
        end

        assign w_expire  = !w_wr && (r_wd_cnt == WD_LAST);
        assign w_tripped = r_trip;
    end else begin : g_no_wd
        assign w_expire  = 1'b0;
        assign w_tripped = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_en     <= '0;
            r_dir    <= '0;
            r_shadow <= '{default: '0};
            r_active <= '{default: '0};
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
                if (w_wrap)
                    r_active[i] <= r_shadow[i];
                if (w_wr && addr == {1'b0, 4'(i)}) begin
                    r_dir[i] <= writedata[0];
                    r_en[i]  <= writedata[1] & ~w_tripped;
                end
                if (w_wr && addr == {1'b1, 4'(i)})
                    r_shadow[i] <= writedata[DUTY_WIDTH-1:0];
            end
            if (w_expire)
                r_en <= '0;
        end
    end

    // Each channel drives at most one leg: a on forward, b on reverse.
    always_comb begin
        w_gpio = '0;
        for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
            w_gpio[2*i]   = r_en[i] & ~r_dir[i] & (r_cnt < r_active[i]);
            w_gpio[2*i+1] = r_en[i] &  r_dir[i] & (r_cnt < r_active[i]);
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_ch == 4'hF) begin
            if (addr[4])
                w_rdata[DUTY_WIDTH-1:0] = r_cnt;
            else
                w_rdata[0] = w_tripped;
        end else begin
            for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
                if (w_ch == 4'(i)) begin
                    if (addr[4])
                        w_rdata[DUTY_WIDTH-1:0] = r_shadow[i];
                    else
                        w_rdata[1:0] = {r_en[i], r_dir[i]};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
            r_gpio     <= '0;
        end else begin
            r_gpio <= w_gpio;
            if (w_rd)
                r_readdata <= w_rdata;
        end
    end

    assign readdata   = r_readdata;
    assign GPIO_out   = r_gpio;
    assign wd_tripped = w_tripped;

endmodule

// File: tb/tb_motor_pwm_slave.sv
// Self-checking bench for motor_pwm_slave: directed scenarios plus randomized bus traffic
// compared each cycle against a time-based behavioural model.
module tb_motor_pwm_slave;

    localparam int unsigned NM  = 6;
    localparam int unsigned DW  = 4;
    localparam int unsigned WDC = 100;
    localparam int unsigned PER = 15;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        cs    = 1'b0;
    logic        wr    = 1'b0;
    logic        rd    = 1'b0;
    logic [4:0]  addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] readdata;
    logic [11:0] gpio;
    logic        wd_tripped;

    int n_vec = 0;
    int n_err = 0;

    motor_pwm_slave #(
        .NUM_MOTORS     (NM),
        .DUTY_WIDTH     (DW),
        .WATCHDOG_CYCLES(WDC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .chipselect(cs),
        .write     (wr),
        .read      (rd),
        .addr      (addr),
        .writedata (wdata),
        .readdata  (readdata),
        .GPIO_out  (gpio),
        .wd_tripped(wd_tripped)
    );

    always #5 clk = ~clk;

    // Reference model: cnt is time since release mod PER, duty latched at each period
    // start, watchdog trips on the WDC-th consecutive cycle without a write.
    int unsigned m_en [NM];
    int unsigned m_dir [NM];
    int unsigned m_shadow [NM];
    int unsigned m_active [NM];
    int unsigned m_cnt;
    int unsigned m_idle;
    logic        m_trip;
    logic [31:0] m_rd;
    logic [11:0] m_gpio;

    task automatic model_reset();
        for (int c = 0; c < NM; c++) begin
            m_en[c] = 0; m_dir[c] = 0; m_shadow[c] = 0; m_active[c] = 0;
        end
        m_cnt = 0; m_idle = 0; m_trip = 1'b0; m_rd = '0; m_gpio = '0;
    endtask

    function automatic logic [31:0] m_read(int unsigned a);
        if (a < NM)                   return 32'(m_en[a] * 2 + m_dir[a]);
        if (a == 15)                  return {31'b0, m_trip};
        if (a >= 16 && a < 16 + NM)   return 32'(m_shadow[a - 16]);
        if (a == 31)                  return 32'(m_cnt);
        return '0;
    endfunction

    task automatic model_step();
        int unsigned a;
        logic [11:0] g;
        a = addr;
        g = '0;
        for (int c = 0; c < NM; c++)
            if (m_en[c] != 0 && m_cnt < m_active[c]) g[2*c + int'(m_dir[c])] = 1'b1;
        m_gpio = g;
        if (cs && rd) m_rd = m_read(a);
        if (m_cnt == PER - 1)
            for (int c = 0; c < NM; c++) m_active[c] = m_shadow[c];
        m_cnt = (m_cnt + 1) % PER;
        if (cs && wr) begin
            m_idle = 0;
            if (a < NM) begin
                m_dir[a] = wdata[0];
                m_en[a]  = m_trip ? 0 : int'(wdata[1]);
            end else if (a == 15) begin
                if (wdata[0]) m_trip = 1'b0;
            end else if (a >= 16 && a < 16 + NM) begin
                m_shadow[a - 16] = wdata[DW-1:0];
            end
        end else begin
            m_idle++;
            if (m_idle >= WDC) begin
                m_trip = 1'b1;
                for (int c = 0; c < NM; c++) m_en[c] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        tick();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a);
        cs = 1'b1; rd = 1'b1; addr = a;
        tick();
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        n_vec++; if (gpio !== 12'h000) begin n_err++; $display("FAIL reset_gpio: got %0h want 0", gpio); end
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL reset_rd: got %0h want 0", readdata); end
        n_vec++; if (wd_tripped !== 1'b0) begin n_err++; $display("FAIL reset_wd: got %0b want 0", wd_tripped); end
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus_read(5'(a));
            exp = (a == 31) ? m_rd : 32'h0;
            n_vec++;
            if (readdata !== exp) begin
                n_err++; $display("FAIL reset_read_%0h: got %0h want %0h", a, readdata, exp);
            end
        end
    endtask

    task automatic test_pwm();
        int duties [3] = '{5, 15, 0};
        int hi, bad, other;
        bus_write(5'h00, 32'h2);
        for (int k = 0; k < 3; k++) begin
            bus_write(5'h10, 32'(duties[k]));
            idle(20);
            hi = 0; bad = 0; other = 0;
            for (int t = 0; t < 45; t++) begin
                tick();
                if (gpio[1:0] == 2'b01) hi++;
                else if (gpio[1:0] != 2'b00) bad++;
                if (gpio[11:2] != 10'h0) other++;
            end
            n_vec++; if (hi != duties[k] * 3) begin n_err++; $display("FAIL pwm_high_d%0d: got %0d want %0d", duties[k], hi, duties[k] * 3); end
            n_vec++; if (bad != 0) begin n_err++; $display("FAIL pwm_b_leg_d%0d: got %0d want 0", duties[k], bad); end
            n_vec++; if (other != 0) begin n_err++; $display("FAIL pwm_other_ch_d%0d: got %0d want 0", duties[k], other); end
        end
    endtask

    task automatic test_boundary();
        int hi;
        bus_write(5'h10, 32'd10);
        idle(20);
        for (int k = 0; k < int'(PER) && m_cnt != 7; k++) tick();
        bus_write(5'h10, 32'd3);
        n_vec++; if (gpio[1:0] !== 2'b01) begin n_err++; $display("FAIL bnd_first: got %0b want 01", gpio[1:0]); end
        hi = (gpio[1:0] == 2'b01) ? 1 : 0;
        for (int t = 0; t < 7; t++) begin
            tick();
            if (gpio[1:0] == 2'b01) hi++;
        end
        n_vec++; if (hi != 3) begin n_err++; $display("FAIL bnd_cur_tail: got %0d want 3", hi); end
        hi = 0;
        for (int t = 0; t < int'(PER); t++) begin
            tick();
            if (gpio[1:0] == 2'b01) hi++;
        end
        n_vec++; if (hi != 3) begin n_err++; $display("FAIL bnd_next: got %0d want 3", hi); end
    endtask

    task automatic test_dir_readback();
        int hi, bad;
        bus_write(5'h02, 32'h3);
        bus_write(5'h12, 32'd8);
        idle(20);
        hi = 0; bad = 0;
        for (int t = 0; t < int'(PER); t++) begin
            tick();
            if (gpio[5]) hi++;
            if (gpio[4]) bad++;
        end
        n_vec++; if (hi != 8) begin n_err++; $display("FAIL dir_b_high: got %0d want 8", hi); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL dir_a_leg: got %0d want 0", bad); end
        bus_read(5'h08);
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL rd_08_a: got %0h want 0", readdata); end
        bus_read(5'h02);
        n_vec++; if (readdata !== 32'h3) begin n_err++; $display("FAIL rd_02: got %0h want 3", readdata); end
        idle(2);
        n_vec++; if (readdata !== 32'h3) begin n_err++; $display("FAIL rd_hold: got %0h want 3", readdata); end
        bus_read(5'h08);
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL rd_08_b: got %0h want 0", readdata); end
    endtask

    task automatic test_watchdog();
        bus_write(5'h10, 32'd15);
        bus_write(5'h00, 32'h2);
        idle(WDC - 1);
        n_vec++; if (wd_tripped !== 1'b0) begin n_err++; $display("FAIL wd_early: got %0b want 0", wd_tripped); end
        tick();
        n_vec++; if (wd_tripped !== 1'b1) begin n_err++; $display("FAIL wd_trip: got %0b want 1", wd_tripped); end
        tick();
        n_vec++; if (gpio !== 12'h000) begin n_err++; $display("FAIL wd_gpio: got %0h want 0", gpio); end
        bus_write(5'h00, 32'h2);
        bus_read(5'h00);
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL wd_ctrl_en: got %0h want 0", readdata); end
        bus_write(5'h00, 32'h3);
        bus_read(5'h00);
        n_vec++; if (readdata !== 32'h1) begin n_err++; $display("FAIL wd_ctrl_dir: got %0h want 1", readdata); end
        bus_write(5'h10, 32'd7);
        bus_read(5'h10);
        n_vec++; if (readdata !== 32'h7) begin n_err++; $display("FAIL wd_duty: got %0h want 7", readdata); end
        bus_read(5'h0F);
        n_vec++; if (readdata !== 32'h1) begin n_err++; $display("FAIL wd_status: got %0h want 1", readdata); end
        n_vec++; if (gpio !== 12'h000) begin n_err++; $display("FAIL wd_gpio_hold: got %0h want 0", gpio); end
        bus_write(5'h0F, 32'h1);
        n_vec++; if (wd_tripped !== 1'b0) begin n_err++; $display("FAIL wd_clear: got %0b want 0", wd_tripped); end
        bus_read(5'h00);
        n_vec++; if (readdata !== 32'h1) begin n_err++; $display("FAIL wd_en_stays: got %0h want 1", readdata); end
        bus_write(5'h00, 32'h2);
        idle(WDC - 1);
        bus_write(5'h07, 32'h0);
        n_vec++; if (wd_tripped !== 1'b0) begin n_err++; $display("FAIL wd_write_wins: got %0b want 0", wd_tripped); end
        bus_read(5'h00);
        n_vec++; if (readdata !== 32'h2) begin n_err++; $display("FAIL wd_en_kept: got %0h want 2", readdata); end
        idle(50);
        n_vec++; if (wd_tripped !== 1'b0) begin n_err++; $display("FAIL wd_late: got %0b want 0", wd_tripped); end
    endtask

    task automatic test_bounds();
        logic [31:0] v1;
        logic [31:0] v2;
        bus_write(5'h07, $urandom);
        bus_write(5'h17, $urandom);
        bus_read(5'h07);
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL bnds_rd07: got %0h want 0", readdata); end
        bus_read(5'h17);
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL bnds_rd17: got %0h want 0", readdata); end
        for (int a = 0; a < int'(NM); a++) begin
            bus_read(5'(a));
            n_vec++; if (readdata !== m_rd) begin n_err++; $display("FAIL bnds_ctrl%0d: got %0h want %0h", a, readdata, m_rd); end
            bus_read(5'(16 + a));
            n_vec++; if (readdata !== m_rd) begin n_err++; $display("FAIL bnds_duty%0d: got %0h want %0h", a, readdata, m_rd); end
        end
        bus_read(5'h1F);
        v1 = readdata;
        idle(2);
        bus_read(5'h1F);
        v2 = readdata;
        n_vec++;
        if ((v2 + PER - v1) % PER != 3) begin
            n_err++; $display("FAIL cnt_delta: got %0d then %0d want difference 3 mod 15", v1, v2);
        end
    endtask

    task automatic test_reset_mid();
        bus_write(5'h00, 32'h2);
        bus_write(5'h10, 32'd15);
        idle(20);
        bus_read(5'h10);
        n_vec++; if (readdata !== 32'd15) begin n_err++; $display("FAIL rstm_pre_rd: got %0h want f", readdata); end
        n_vec++; if (gpio[1:0] !== 2'b01) begin n_err++; $display("FAIL rstm_pre_gpio: got %0b want 01", gpio[1:0]); end
        #2 reset = 1'b1;
        model_reset();
        #1;
        n_vec++; if (gpio !== 12'h000) begin n_err++; $display("FAIL rstm_gpio: got %0h want 0", gpio); end
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL rstm_rd: got %0h want 0", readdata); end
        @(negedge clk);
        reset = 1'b0;
        bus_read(5'h10);
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL rstm_duty0: got %0h want 0", readdata); end
        bus_read(5'h00);
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL rstm_ctrl0: got %0h want 0", readdata); end
        bus_read(5'h1F);
        n_vec++; if (readdata !== 32'h2) begin n_err++; $display("FAIL rstm_cnt: got %0h want 2", readdata); end
    endtask

    task automatic test_random();
        int burst;
        int p, r;
        burst = 0;
        for (int it = 0; it < 900; it++) begin
            if (it % 300 == 150) burst = WDC + 5;
            if (burst > 0) begin
                burst--;
            end else begin
                p = $urandom_range(0, 9);
                r = $urandom_range(0, 7);
                case (r)
                    0, 1, 2: addr = 5'($urandom_range(0, 7));
                    3, 4:    addr = 5'(16 + $urandom_range(0, 7));
                    5:       addr = 5'h0F;
                    6:       addr = 5'h1F;
                    default: addr = 5'($urandom_range(0, 31));
                endcase
                wdata = $urandom;
                cs = 1'b1;
                wr = (p < 3);
                rd = (p >= 3 && p < 6);
            end
            tick();
            cs = 1'b0; wr = 1'b0; rd = 1'b0;
            n_vec++; if (readdata !== m_rd) begin n_err++; $display("FAIL rnd_rd@%0d: got %0h want %0h", it, readdata, m_rd); end
            n_vec++; if (gpio !== m_gpio) begin n_err++; $display("FAIL rnd_gpio@%0d: got %0h want %0h", it, gpio, m_gpio); end
            n_vec++; if (wd_tripped !== m_trip) begin n_err++; $display("FAIL rnd_wd@%0d: got %0b want %0b", it, wd_tripped, m_trip); end
        end
    endtask

    initial begin
        test_reset();
        test_pwm();
        test_boundary();
        test_dir_readback();
        test_watchdog();
        test_bounds();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
